// File: rtl/e203_exu_rf.sv
// ---------------------------------------------------------------------------
// e203_exu_rf -- integer register file of the E203 execution unit.
//
// x0 has no storage and always reads 0. x1..x(NREGS-1) are XLEN flops each.
// Both read ports are purely combinational and have no write bypass, so a
// write becomes visible only after the clock edge. x1 is also exported
// continuously on x1_r for the IFU branch predictor.
//
// Configuration macro: E203_RFREG_NUM_16_EN
//   undefined : 32 registers (RV32I).
//   defined   : 16 registers (RV32E). Indices with idx[4]=1 read 0 and
//               writes to them are dropped.
//
// Ports
//   clk            clock, all state updates on the rising edge
//   rst_n          synchronous reset, active HIGH despite the name
//                  (1 = clear x1..x31). Reset wins over a same-cycle write.
//   test_mode      DFT clock-gate bypass; has no functional effect
//   read_src1_idx  read port 1 index      read_src1_dat  read port 1 data
//   read_src2_idx  read port 2 index      read_src2_dat  read port 2 data
//   wbck_dest_wen  writeback enable
//   wbck_dest_idx  writeback index (writes to 0 are dropped)
//   wbck_dest_dat  writeback data
//   x1_r           current contents of x1
// ---------------------------------------------------------------------------

// One architectural register: reset-to-zero flop with a write enable.
module e203_exu_rf_ent #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_i,
    input  logic            we_i,
    input  logic [XLEN-1:0] dat_i,
    output logic [XLEN-1:0] q_o
);
    logic [XLEN-1:0] q_q;
    logic [XLEN-1:0] q_d;

    assign q_d = we_i ? dat_i : q_q;

    always_ff @(posedge clk) begin
        if (rst_i) q_q <= '0;
        else       q_q <= q_d;
    end

    assign q_o = q_q;
endmodule

module e203_exu_rf #(
    parameter int XLEN        = 32,
    parameter int RFIDX_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   test_mode,
    input  logic [RFIDX_WIDTH-1:0] read_src1_idx,
    output logic [XLEN-1:0]        read_src1_dat,
    input  logic [RFIDX_WIDTH-1:0] read_src2_idx,
    output logic [XLEN-1:0]        read_src2_dat,
    input  logic                   wbck_dest_wen,
    input  logic [RFIDX_WIDTH-1:0] wbck_dest_idx,
    input  logic [XLEN-1:0]        wbck_dest_dat,
    output logic [XLEN-1:0]        x1_r
);
`ifdef E203_RFREG_NUM_16_EN
    localparam int NREGS = 16;
`else
    localparam int NREGS = 32;
`endif
    localparam int IDXW = $clog2(NREGS);

    // Entry 0 is a hard zero; the rest come from the per-register flops.
    logic [NREGS-1:0][XLEN-1:0] rf;

    assign rf[0] = '0;

    genvar k;
    generate
        for (k = 1; k < NREGS; k++) begin : g_reg
            logic we;
            // Full-width compare: in 16-entry mode an index with idx[4]=1
            // never matches k < 16, so those writes drop naturally.
            assign we = wbck_dest_wen && (wbck_dest_idx == RFIDX_WIDTH'(k));

            e203_exu_rf_ent #(.XLEN(XLEN)) u_ent (
                .clk   (clk),
                .rst_i (rst_n),
                .we_i  (we),
                .dat_i (wbck_dest_dat),
                .q_o   (rf[k])
            );
        end
    endgenerate

`ifdef E203_RFREG_NUM_16_EN
    // Unimplemented upper half reads as zero.
    assign read_src1_dat = read_src1_idx[RFIDX_WIDTH-1] ? '0 : rf[read_src1_idx[IDXW-1:0]];
    assign read_src2_dat = read_src2_idx[RFIDX_WIDTH-1] ? '0 : rf[read_src2_idx[IDXW-1:0]];
`else
    assign read_src1_dat = rf[read_src1_idx[IDXW-1:0]];
    assign read_src2_dat = rf[read_src2_idx[IDXW-1:0]];
`endif

    assign x1_r = rf[1];

    // test_mode only steers clock-gate bypass in the gated-clock variant;
    // with plain enable flops it has nothing to drive.
    logic unused_test_mode;
    assign unused_test_mode = test_mode;
endmodule

// File: tb/tb_e203_exu_rf.sv
module tb_e203_exu_rf;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        test_mode;
    logic [4:0]  read_src1_idx, read_src2_idx, wbck_dest_idx;
    logic [31:0] read_src1_dat, read_src2_dat, wbck_dest_dat, x1_r;
    logic        wbck_dest_wen;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    e203_exu_rf dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .test_mode     (test_mode),
        .read_src1_idx (read_src1_idx),
        .read_src1_dat (read_src1_dat),
        .read_src2_idx (read_src2_idx),
        .read_src2_dat (read_src2_dat),
        .wbck_dest_wen (wbck_dest_wen),
        .wbck_dest_idx (wbck_dest_idx),
        .wbck_dest_dat (wbck_dest_dat),
        .x1_r          (x1_r)
    );

    typedef struct {
        logic        rst;
        logic        wen;
        logic [4:0]  widx;
        logic [31:0] wdat;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic        tm;
        logic [31:0] e1;   // expected reads after the edge
        logic [31:0] e2;
        logic [31:0] ex1;
    } vec_t;

    vec_t tv [9];
    logic [31:0] model [32];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one rising edge and settle 1ns past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b1; test_mode = 1'b0; wbck_dest_wen = 1'b0;
        wbck_dest_idx = '0; wbck_dest_dat = '0;
        read_src1_idx = '0; read_src2_idx = '0;

        // Reset: two edges, then sweep every index on both ports.
        step(); step();
        rst_n = 1'b0;
        for (int i = 0; i < 32; i++) begin
            read_src1_idx = 5'(i);
            read_src2_idx = 5'(31 - i);
            #1;
            chk($sformatf("rst_src1_x%0d", i), read_src1_dat, 32'h0);
            chk($sformatf("rst_src2_x%0d", 31 - i), read_src2_dat, 32'h0);
        end
        chk("rst_x1_r", x1_r, 32'h0);

        // Directed vectors, applied in order, checked after each edge.
        tv[0] = '{1'b0, 1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd5,  1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0};
        tv[1] = '{1'b0, 1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd5,  1'b1, 32'h0,        32'hDEADBEEF, 32'h0};
        tv[2] = '{1'b0, 1'b1, 5'd1,  32'h80000004, 5'd1,  5'd0,  1'b0, 32'h80000004, 32'h0,        32'h80000004};
        tv[3] = '{1'b0, 1'b1, 5'd3,  32'h00000033, 5'd3,  5'd1,  1'b1, 32'h00000033, 32'h80000004, 32'h80000004};
        tv[4] = '{1'b0, 1'b0, 5'd3,  32'h00000055, 5'd3,  5'd5,  1'b0, 32'h00000033, 32'hDEADBEEF, 32'h80000004};
        tv[5] = '{1'b0, 1'b0, 5'd3,  32'h00000055, 5'd3,  5'd5,  1'b1, 32'h00000033, 32'hDEADBEEF, 32'h80000004};
        tv[6] = '{1'b0, 1'b1, 5'd31, 32'hA5A5A5A5, 5'd31, 5'd30, 1'b0, 32'hA5A5A5A5, 32'h0,        32'h80000004};
        tv[7] = '{1'b0, 1'b1, 5'd16, 32'h12345678, 5'd16, 5'd15, 1'b1, 32'h12345678, 32'h0,        32'h80000004};
        tv[8] = '{1'b1, 1'b1, 5'd3,  32'h00000077, 5'd3,  5'd1,  1'b0, 32'h0,        32'h0,        32'h0};

        for (int i = 0; i < 9; i++) begin
            rst_n = tv[i].rst; wbck_dest_wen = tv[i].wen;
            wbck_dest_idx = tv[i].widx; wbck_dest_dat = tv[i].wdat;
            read_src1_idx = tv[i].r1; read_src2_idx = tv[i].r2;
            test_mode = tv[i].tm;
            step();
            chk($sformatf("vec%0d_src1", i), read_src1_dat, tv[i].e1);
            chk($sformatf("vec%0d_src2", i), read_src2_dat, tv[i].e2);
            chk($sformatf("vec%0d_x1_r", i), x1_r, tv[i].ex1);
        end
        rst_n = 1'b0; wbck_dest_wen = 1'b0;

        // Read-during-write: old value before the edge, new value after it.
        wbck_dest_wen = 1'b1; wbck_dest_idx = 5'd7; wbck_dest_dat = 32'h11;
        step();
        wbck_dest_dat = 32'h22; read_src1_idx = 5'd7; read_src2_idx = 5'd7;
        #1;
        chk("rdw_before_edge", read_src1_dat, 32'h11);
        step();
        wbck_dest_wen = 1'b0;
        chk("rdw_after_edge", read_src1_dat, 32'h22);
        chk("rdw_after_edge_p2", read_src2_dat, 32'h22);

        // Random sweep against a 32-entry model, starting from a reset.
        rst_n = 1'b1; step(); rst_n = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        for (int c = 0; c < 1000; c++) begin
            logic rst_r;
            rst_r         = ($urandom_range(99) < 2);
            rst_n         = rst_r;
            test_mode     = 1'($urandom);
            wbck_dest_wen = 1'($urandom);
            wbck_dest_idx = 5'($urandom);
            wbck_dest_dat = $urandom;
            read_src1_idx = 5'($urandom);
            read_src2_idx = ($urandom_range(3) == 0) ? wbck_dest_idx : 5'($urandom);
            #1;
            chk($sformatf("rnd%0d_src1", c), read_src1_dat, model[read_src1_idx]);
            chk($sformatf("rnd%0d_src2", c), read_src2_dat, model[read_src2_idx]);
            if (rst_r) begin
                for (int i = 0; i < 32; i++) model[i] = 32'h0;
            end else if (wbck_dest_wen && wbck_dest_idx != 5'd0) begin
                model[wbck_dest_idx] = wbck_dest_dat;
            end
            step();
            chk($sformatf("rnd%0d_x1_r", c), x1_r, model[1]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
